// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset_seq sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    COUNT = 2'd1,
    STAGE = 2'd2,
    RUN   = 2'd3
  } state_e;

  // Counter width for a count of n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_seq_sync.sv
// Parametrised-width 2-flop synchronizer with a configurable reset value.
module reset_seq_sync #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/reset_seq.sv
// reset_seq: power-on delay, then ordered release of NUM_CH reset channels.
// Define RESET_SEQ_DEBOUNCE_EN to filter the synchronized reset request.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int NUM_CH          = 3,
  parameter int NUM_LOCKS       = 2,
  parameter int POR_CYCLES      = 16777215,
  parameter int STAGE_CYCLES    = 16,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rst_req,
  input  logic [NUM_LOCKS-1:0] locks,
  output logic [NUM_CH-1:0]    rst_out,
  output logic                 all_ok,
  output logic                 lock_lost
);

  localparam int POR_W = cnt_width(POR_CYCLES);
  localparam int STG_W = cnt_width(STAGE_CYCLES);
  localparam int IDX_W = cnt_width(NUM_CH);

  localparam logic [POR_W-1:0] POR_LAST = POR_W'(POR_CYCLES - 1);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(STAGE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

  if (NUM_CH < 1 || NUM_LOCKS < 1 || POR_CYCLES < 1 || STAGE_CYCLES < 1 ||
      DEBOUNCE_CYCLES < 1) begin : g_bad_params
    $error("reset_seq: every parameter must be at least 1");
  end

  logic                 req_s;
  logic [NUM_LOCKS-1:0] locks_s;
  logic                 req_f;
  logic                 lock_fault;
  logic                 fault;

  reset_seq_sync #(
    .W       (1),
    .RST_VAL (1'b1)
  ) u_req_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rst_req),
    .q       (req_s)
  );

  reset_seq_sync #(
    .W       (NUM_LOCKS),
    .RST_VAL ({NUM_LOCKS{1'b0}})
  ) u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (locks),
    .q       (locks_s)
  );

`ifdef RESET_SEQ_DEBOUNCE_EN
  localparam int DEB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic             req_f_q, req_f_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

  // The filtered request flips only after req_s disagrees with it for
  // DEBOUNCE_CYCLES consecutive samples; any agreement restarts the count.
  always_comb begin
    req_f_d   = req_f_q;
    deb_cnt_d = '0;
    if (req_s != req_f_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        req_f_d = req_s;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_f_q   <= 1'b1;
      deb_cnt_q <= '0;
    end else begin
      req_f_q   <= req_f_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign req_f = req_f_q;
`else
  assign req_f = req_s;
`endif

  assign lock_fault = ~(&locks_s);
  assign fault      = req_f | lock_fault;

  state_e              state_q, state_d;
  logic [POR_W-1:0]    por_cnt_q, por_cnt_d;
  logic [STG_W-1:0]    stg_cnt_q, stg_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_CH-1:0]   rst_out_q, rst_out_d;
  logic                lock_lost_q, lock_lost_d;

  always_comb begin
    state_d   = state_q;
    por_cnt_d = por_cnt_q;
    stg_cnt_d = stg_cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;

    case (state_q)
      HOLD: begin
        rst_out_d = '1;
        por_cnt_d = '0;
        stg_cnt_d = '0;
        idx_d     = '0;
        if (!fault) state_d = COUNT;
      end
      COUNT: begin
        if (por_cnt_q == POR_LAST) begin
          por_cnt_d = '0;
          idx_d     = '0;
          rst_out_d = rst_out_q << 1;
          state_d   = (NUM_CH == 1) ? RUN : STAGE;
        end else begin
          por_cnt_d = por_cnt_q + POR_W'(1);
        end
      end
      STAGE: begin
        // Channels clear as a growing run of zeros from bit 0 upward.
        if (stg_cnt_q == STG_LAST) begin
          stg_cnt_d = '0;
          idx_d     = idx_q + IDX_W'(1);
          rst_out_d = rst_out_q << 1;
          if (idx_d == IDX_LAST) state_d = RUN;
        end else begin
          stg_cnt_d = stg_cnt_q + STG_W'(1);
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = HOLD;
      end
    endcase

    if (fault && state_q != HOLD) begin
      state_d   = HOLD;
      rst_out_d = '1;
      por_cnt_d = '0;
      stg_cnt_d = '0;
      idx_d     = '0;
    end
  end

  // A request clears the sticky flag even in the cycle a lock loss sets it.
  always_comb begin
    lock_lost_d = lock_lost_q;
    if (state_q == RUN && lock_fault) lock_lost_d = 1'b1;
    if (req_f) lock_lost_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HOLD;
      por_cnt_q   <= '0;
      stg_cnt_q   <= '0;
      idx_q       <= '0;
      rst_out_q   <= '1;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      por_cnt_q   <= por_cnt_d;
      stg_cnt_q   <= stg_cnt_d;
      idx_q       <= idx_d;
      rst_out_q   <= rst_out_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign rst_out   = rst_out_q;
  assign all_ok    = (state_q == RUN);
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_reset_seq.sv
// Self-checking bench for reset_seq: a 3-channel instance and a 1-channel,
// 1-cycle-POR instance share stimulus and are checked against a timing model.
`timescale 1ns/1ps
module tb_reset_seq;

  localparam int NC  = 3;
  localparam int NL  = 2;
  localparam int POR = 8;
  localparam int STG = 4;
  localparam int DEB = 4;
  localparam int CAP = 100000;
`ifdef RESET_SEQ_DEBOUNCE_EN
  localparam int OFS = DEB;
  localparam int PL  = DEB + 1;
`else
  localparam int OFS = 0;
  localparam int PL  = 2;
`endif

  logic          clk     = 1'b0;
  logic          reset_n = 1'b1;
  logic          rst_req = 1'b0;
  logic [NL-1:0] locks   = '1;

  logic [NC-1:0] rst_out;
  logic          all_ok;
  logic          lock_lost;
  logic [0:0]    rst_out1;
  logic          all_ok1;
  logic          lock_lost1;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reset_seq #(
    .NUM_CH(NC), .NUM_LOCKS(NL), .POR_CYCLES(POR), .STAGE_CYCLES(STG), .DEBOUNCE_CYCLES(DEB)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .rst_req(rst_req), .locks(locks),
    .rst_out(rst_out), .all_ok(all_ok), .lock_lost(lock_lost)
  );

  reset_seq #(
    .NUM_CH(1), .NUM_LOCKS(NL), .POR_CYCLES(1), .STAGE_CYCLES(STG), .DEBOUNCE_CYCLES(DEB)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n), .rst_req(rst_req), .locks(locks),
    .rst_out(rst_out1), .all_ok(all_ok1), .lock_lost(lock_lost1)
  );

  // Reference model. m_d is the number of edges since fault last fell
  // (0 while faulted); every output is a threshold on that count.
  logic          m_meta_req, m_req_s, m_req_f, m_rf, m_fault;
  logic [NL-1:0] m_meta_lk, m_lk_s;
  int            m_deb, m_d;
  logic          m_ll, m_ll1;

  function automatic logic [NC-1:0] exp_rst(input int d);
    logic [NC-1:0] r;
    r = '1;
    for (int k = 0; k < NC; k++)
      if (d > 0 && d >= POR + 1 + k * STG) r[k] = 1'b0;
    return r;
  endfunction

  function automatic logic exp_ok(input int d);
    return (d > 0) && (d >= POR + 1 + (NC - 1) * STG);
  endfunction

  function automatic logic exp_ok1(input int d);
    return d >= 2;
  endfunction

`ifdef RESET_SEQ_DEBOUNCE_EN
  assign m_rf = m_req_f;
`else
  assign m_rf = m_req_s;
`endif
  assign m_fault = m_rf | ~(&m_lk_s);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_meta_req <= 1'b1;
      m_req_s    <= 1'b1;
      m_meta_lk  <= '0;
      m_lk_s     <= '0;
      m_req_f    <= 1'b1;
      m_deb      <= 0;
      m_d        <= 0;
      m_ll       <= 1'b0;
      m_ll1      <= 1'b0;
    end else begin
      m_meta_req <= rst_req;
      m_req_s    <= m_meta_req;
      m_meta_lk  <= locks;
      m_lk_s     <= m_meta_lk;
      if (m_req_s == m_req_f) m_deb <= 0;
      else if (m_deb + 1 >= DEB) begin
        m_req_f <= m_req_s;
        m_deb   <= 0;
      end else m_deb <= m_deb + 1;
      m_d   <= m_fault ? 0 : ((m_d < CAP) ? m_d + 1 : m_d);
      m_ll  <= m_rf ? 1'b0 : (m_ll  | (exp_ok(m_d)  & ~(&m_lk_s)));
      m_ll1 <= m_rf ? 1'b0 : (m_ll1 | (exp_ok1(m_d) & ~(&m_lk_s)));
    end
  end

  function automatic logic [7:0] model_vec();
    return {exp_rst(m_d), exp_ok(m_d), m_ll, ~exp_ok1(m_d), exp_ok1(m_d), m_ll1};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {rst_out, all_ok, lock_lost, rst_out1, all_ok1, lock_lost1};
  endfunction

  task automatic test_reset;
    logic [NC-1:0] exp_r;
    #1 reset_n = 1'b0;
    rst_req = 1'b0;
    locks   = '1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({rst_out, all_ok, lock_lost, rst_out1, all_ok1} !== 7'b111_0_0_1_0) begin
      miscompares++;
      $display("FAIL reset_values got %b want %b",
               {rst_out, all_ok, lock_lost, rst_out1, all_ok1}, 7'b111_0_0_1_0);
    end
    reset_n = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      exp_r = (n >= 19 + OFS) ? 3'b000 : (n >= 15 + OFS) ? 3'b100 :
              (n >= 11 + OFS) ? 3'b110 : 3'b111;
      vectors++;
      if ({rst_out, all_ok} !== {exp_r, (n >= 19 + OFS)}) begin
        miscompares++;
        $display("FAIL startup edge %0d got %b/%b want %b/%b", n, rst_out, all_ok,
                 exp_r, (n >= 19 + OFS));
      end
      vectors++;
      if ({rst_out1, all_ok1} !== {(n < 4 + OFS), (n >= 4 + OFS)}) begin
        miscompares++;
        $display("FAIL startup_1ch edge %0d got %b/%b want %b/%b", n, rst_out1, all_ok1,
                 (n < 4 + OFS), (n >= 4 + OFS));
      end
    end
  endtask

  task automatic test_lock_drop;
    locks = 2'b01;
    @(negedge clk);
    locks = 2'b11;
    for (int n = 2; n <= 40; n++) begin
      @(negedge clk);
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL lock_drop edge %0d got %b want %b", n, dut_vec(), model_vec());
      end
      if (n == 3) begin
        vectors++;
        if ({rst_out, lock_lost} !== 4'b111_1) begin
          miscompares++;
          $display("FAIL lock_drop_hit got %b want %b", {rst_out, lock_lost}, 4'b1111);
        end
      end
    end
    vectors++;
    if ({all_ok, lock_lost} !== 2'b11) begin
      miscompares++;
      $display("FAIL lock_drop_sticky got %b want %b", {all_ok, lock_lost}, 2'b11);
    end
  endtask

  task automatic test_req_mid_count;
    bit hit;
    locks = 2'b10;
    @(negedge clk);
    locks = 2'b11;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL req_wait got %b want %b", dut_vec(), model_vec());
      end
      if (m_d == 6) hit = 1'b1;
    end
    vectors++;
    if (!hit || lock_lost !== 1'b1) begin
      miscompares++;
      $display("FAIL req_reach_count5 got hit=%0b lock_lost=%b want 1/1", hit, lock_lost);
    end
    rst_req = 1'b1;
    repeat (PL) @(negedge clk);
    rst_req = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL req_mid_count cyc %0d got %b want %b", n, dut_vec(), model_vec());
      end
    end
    vectors++;
    if ({all_ok, lock_lost} !== 2'b10) begin
      miscompares++;
      $display("FAIL req_clears_lost got %b want %b", {all_ok, lock_lost}, 2'b10);
    end
  endtask

  task automatic test_async_reset;
    bit hit;
    locks = 2'b01;
    @(negedge clk);
    locks = 2'b11;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL areset_wait got %b want %b", dut_vec(), model_vec());
      end
      if (exp_rst(m_d) == 3'b110) hit = 1'b1;
    end
    vectors++;
    if (!hit || {rst_out, lock_lost} !== 4'b110_1) begin
      miscompares++;
      $display("FAIL areset_reach got hit=%0b %b want 1 %b", hit, {rst_out, lock_lost}, 4'b1101);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({rst_out, all_ok, lock_lost, rst_out1, all_ok1, lock_lost1} !== 8'b111_0_0_1_0_0) begin
      miscompares++;
      $display("FAIL areset_immediate got %b want %b",
               {rst_out, all_ok, lock_lost, rst_out1, all_ok1, lock_lost1}, 8'b11100100);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL areset_restart cyc %0d got %b want %b", n, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_debounce;
    bit seen;
`ifdef RESET_SEQ_DEBOUNCE_EN
    rst_req = 1'b1;
    repeat (3) @(negedge clk);
    rst_req = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      vectors++;
      if (rst_out !== 3'b000 || dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL debounce_short cyc %0d got %b want %b", n, dut_vec(), model_vec());
      end
    end
    rst_req = 1'b1;
    repeat (4) @(negedge clk);
`else
    rst_req = 1'b1;
    repeat (2) @(negedge clk);
`endif
    rst_req = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (rst_out === 3'b111) seen = 1'b1;
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL debounce_long cyc %0d got %b want %b", n, dut_vec(), model_vec());
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL debounce_pulse_resets got seen=0 want seen=1");
    end
  endtask

  task automatic test_random;
    int lk_left  = 0;
    int req_left = 0;
    int ev;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL random cyc %0d got %b want %b", n, dut_vec(), model_vec());
      end
      if (lk_left > 0) lk_left--;
      if (req_left > 0) req_left--;
      if (lk_left == 0) locks = '1;
      if (req_left == 0) rst_req = 1'b0;
      ev = $urandom_range(0, 99);
      if (ev < 3 && lk_left == 0) begin
        lk_left = $urandom_range(1, 3);
        locks   = NL'($urandom_range(0, (1 << NL) - 2));
      end else if (ev < 6 && req_left == 0) begin
        req_left = $urandom_range(1, 8);
        rst_req  = 1'b1;
      end
    end
    locks   = '1;
    rst_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lock_drop();
    test_req_mid_count();
    test_async_reset();
    test_debounce();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
